// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter.
//   state_t : arbiter FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   owner_t : which requester owns the current SRAM transaction
//   lat_load: converts the integer read latency into the wait-counter width
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_t;

  // Read latency is limited to 1..3, so two bits hold the countdown.
  localparam int LAT_CNT_W = 2;

  function automatic logic [LAT_CNT_W-1:0] lat_load(input int rl);
    return LAT_CNT_W'(rl);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-input round-robin picker, purely combinational.
//   req[1:0] : request vector (bit 0 = requester 0, bit 1 = requester 1)
//   last     : index of the requester granted most recently
//   grant    : one-hot grant, all zero when nobody requests
//   winner   : index of the granted requester (0 when nobody requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // On contention the side that did not win last time goes first.
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
    if (|req) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one line-wide SRAM port between the I-cache refill path (IF side)
// and the D-cache refill/writeback path (D side). One access is in flight at
// a time; contention is resolved round-robin. Reads return data to the
// originator with a one-cycle rvalid pulse.
//
// Ports:
//   clk_sys_i, rst_i           clock, asynchronous active-high reset
//   if_req_i/wea/addr/data     IF-side command (req held until if_gnt_o)
//   if_gnt_o                   pulse: IF command is on the SRAM port
//   if_rvalid_o, if_rdata_o    IF read completion pulse and held read line
//   d_*                        same set for the D side
//   SRAM_ena_o/wea/addr/data   SRAM command port
//   SRAM_data_i                SRAM read data
//   busy_o                     high whenever the FSM is not idle
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_BIT = 10,
  parameter int SRAM_DATA_BIT = 256,
  parameter int READ_LATENCY  = 1
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_i,

  input  logic                     if_req_i,
  input  logic                     if_wea_i,
  input  logic [SRAM_ADDR_BIT-1:0] if_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] if_data_i,
  output logic                     if_gnt_o,
  output logic                     if_rvalid_o,
  output logic [SRAM_DATA_BIT-1:0] if_rdata_o,

  input  logic                     d_req_i,
  input  logic                     d_wea_i,
  input  logic [SRAM_ADDR_BIT-1:0] d_addr_i,
  input  logic [SRAM_DATA_BIT-1:0] d_data_i,
  output logic                     d_gnt_o,
  output logic                     d_rvalid_o,
  output logic [SRAM_DATA_BIT-1:0] d_rdata_o,

  output logic                     SRAM_ena_o,
  output logic                     SRAM_wea_o,
  output logic [SRAM_ADDR_BIT-1:0] SRAM_addr_o,
  output logic [SRAM_DATA_BIT-1:0] SRAM_data_o,
  input  logic [SRAM_DATA_BIT-1:0] SRAM_data_i,

  output logic                     busy_o
);

  state_t                   state_q, state_d;
  owner_t                   last_grant_q;
  owner_t                   owner_q;
  logic                     wea_q;
  logic [SRAM_ADDR_BIT-1:0] addr_q;
  logic [SRAM_DATA_BIT-1:0] data_q;
  logic [LAT_CNT_W-1:0]     lat_cnt_q;
  logic [SRAM_DATA_BIT-1:0] if_rdata_q;
  logic [SRAM_DATA_BIT-1:0] d_rdata_q;

  logic [1:0] arb_grant;
  logic       arb_winner;
  owner_t     arb_owner;

  // Requests are only looked at in IDLE; the picker itself is stateless.
  rr_arb2 u_rr_arb2 (
    .req    ({d_req_i, if_req_i}),
    .last   (last_grant_q),
    .grant  (arb_grant),
    .winner (arb_winner)
  );

  assign arb_owner = owner_t'(arb_winner);

  // ---- State register ----
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- Next state and control outputs (decoded from the current state) ----
  always_comb begin
    state_d     = state_q;
    SRAM_ena_o  = 1'b0;
    SRAM_wea_o  = 1'b0;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    d_rvalid_o  = 1'b0;
    busy_o      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        SRAM_ena_o = 1'b1;
        SRAM_wea_o = wea_q;
        if (owner_q == OWNER_D) begin
          d_gnt_o = 1'b1;
        end else begin
          if_gnt_o = 1'b1;
        end
        // A write is finished once it is on the port; the grant is its ack.
        state_d = wea_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt_q == LAT_CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q == OWNER_D) begin
          d_rvalid_o = 1'b1;
        end else begin
          if_rvalid_o = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- Command latch, latency counter and per-side read data ----
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= OWNER_D;
      owner_q      <= OWNER_IF;
      wea_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      lat_cnt_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|arb_grant) begin
            // last_grant tracks every grant, including uncontended ones.
            owner_q      <= arb_owner;
            last_grant_q <= arb_owner;
            wea_q        <= arb_grant[1] ? d_wea_i  : if_wea_i;
            addr_q       <= arb_grant[1] ? d_addr_i : if_addr_i;
            data_q       <= arb_grant[1] ? d_data_i : if_data_i;
          end
        end
        ST_ISSUE: begin
          if (!wea_q) begin
            lat_cnt_q <= lat_load(READ_LATENCY);
          end
        end
        ST_WAIT: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          // Count of 1 marks the cycle READ_LATENCY after ena: data is valid.
          if (lat_cnt_q == LAT_CNT_W'(1)) begin
            if (owner_q == OWNER_D) begin
              d_rdata_q <= SRAM_data_i;
            end else begin
              if_rdata_q <= SRAM_data_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address/data hold their last latched command between issues.
  assign SRAM_addr_o = addr_q;
  assign SRAM_data_o = data_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 256;
  localparam int K_GNT_IF = 0;
  localparam int K_GNT_D  = 1;
  localparam int K_RV_IF  = 2;
  localparam int K_RV_D   = 3;
  localparam bit S_IF = 1'b0;
  localparam bit S_D  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: READ_LATENCY=1 instance, index 1: READ_LATENCY=3 instance.
  logic          if_req [2];
  logic          if_wea [2];
  logic [AW-1:0] if_addr[2];
  logic [DW-1:0] if_data[2];
  logic          d_req  [2];
  logic          d_wea  [2];
  logic [AW-1:0] d_addr [2];
  logic [DW-1:0] d_data [2];
  wire           if_gnt[2], if_rvalid[2], d_gnt[2], d_rvalid[2];
  wire [DW-1:0]  if_rdata[2], d_rdata[2];
  wire           sram_ena[2], sram_wea[2], busy[2];
  wire [AW-1:0]  sram_addr[2];
  wire [DW-1:0]  sram_wdata[2], sram_rdata[2];

  typedef struct {
    int            dut;
    int            kind;
    int            at;
    logic          wea;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  // SRAM contents: address 0x005 holds A5 in every byte, others {16{addr}}.
  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    if (a == 10'h005) return {32{8'hA5}};
    return {16{6'b0, a}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int RL = (g == 0) ? 1 : 3;

    sram_port_arbiter #(
      .SRAM_ADDR_BIT(AW), .SRAM_DATA_BIT(DW), .READ_LATENCY(RL)
    ) u_dut (
      .clk_sys_i   (clk),
      .rst_i       (rst),
      .if_req_i    (if_req[g]),
      .if_wea_i    (if_wea[g]),
      .if_addr_i   (if_addr[g]),
      .if_data_i   (if_data[g]),
      .if_gnt_o    (if_gnt[g]),
      .if_rvalid_o (if_rvalid[g]),
      .if_rdata_o  (if_rdata[g]),
      .d_req_i     (d_req[g]),
      .d_wea_i     (d_wea[g]),
      .d_addr_i    (d_addr[g]),
      .d_data_i    (d_data[g]),
      .d_gnt_o     (d_gnt[g]),
      .d_rvalid_o  (d_rvalid[g]),
      .d_rdata_o   (d_rdata[g]),
      .SRAM_ena_o  (sram_ena[g]),
      .SRAM_wea_o  (sram_wea[g]),
      .SRAM_addr_o (sram_addr[g]),
      .SRAM_data_o (sram_wdata[g]),
      .SRAM_data_i (sram_rdata[g]),
      .busy_o      (busy[g])
    );

    // Read data is valid exactly RL cycles after ena; garbage otherwise.
    logic [2:0]    rd_hist = '0;
    logic [AW-1:0] a_hist [3];
    always @(posedge clk) begin
      rd_hist   <= {rd_hist[1:0], sram_ena[g] & ~sram_wea[g]};
      a_hist[0] <= sram_addr[g];
      a_hist[1] <= a_hist[0];
      a_hist[2] <= a_hist[1];
    end
    assign sram_rdata[g] = rd_hist[RL-1] ? word_of(a_hist[RL-1])
                                         : {8{16'hDEAD, cyc[15:0]}};
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s: got %s required %s", name, act, req);
  endtask

  task automatic push(input int g, input int k, input int at, input logic wea,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    e.dut = g; e.kind = k; e.at = at; e.wea = wea; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic logic pulse(input int g, input int k);
    case (k)
      K_GNT_IF: return if_gnt[g];
      K_GNT_D:  return d_gnt[g];
      K_RV_IF:  return if_rvalid[g];
      default:  return d_rvalid[g];
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a DUT presents a pulse.
  logic [DW-1:0] sh_if[2];
  logic [DW-1:0] sh_d [2];
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int g = 0; g < 2; g++) begin
          sh_if[g] = '0;
          sh_d[g]  = '0;
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
          e = exp_q.pop_front();
          fail_evt("missed_event", "no pulse",
                   $sformatf("dut %0d kind %0d at cycle %0d", e.dut, e.kind, e.at));
        end
        for (int g = 0; g < 2; g++) begin
          chk1("ena_eq_gnt", sram_ena[g], if_gnt[g] | d_gnt[g]);
          chk1("wea_without_ena", sram_wea[g] & ~sram_ena[g], 1'b0);
          for (int k = 0; k < 4; k++) begin
            if (pulse(g, k)) begin
              if (exp_q.size() == 0) begin
                fail_evt("unexpected_pulse",
                         $sformatf("dut %0d kind %0d at cycle %0d", g, k, cyc), "no pulse");
              end else begin
                e = exp_q.pop_front();
                chk_int("event_dut", g, e.dut);
                chk_int("event_kind", k, e.kind);
                chk_int("event_cycle", cyc, e.at);
                if (k < 2) begin
                  chk1("sram_wea", sram_wea[g], e.wea);
                  chk("sram_addr", DW'(sram_addr[g]), DW'(e.addr));
                  if (e.wea) chk("sram_wdata", sram_wdata[g], e.data);
                end else begin
                  chk("rdata", (k == K_RV_IF) ? if_rdata[g] : d_rdata[g], e.data);
                  if (k == K_RV_IF) sh_if[g] = e.data;
                  else              sh_d[g]  = e.data;
                end
              end
            end
          end
          chk("if_rdata_hold", if_rdata[g], sh_if[g]);
          chk("d_rdata_hold", d_rdata[g], sh_d[g]);
        end
      end
    end
  end

  // Drives one request and holds it until the grant is seen (bounded).
  task automatic side_txn(input int g, input bit side, input logic wea,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit hold);
    bit got = 1'b0;
    if (side == S_IF) begin
      if_req[g] = 1'b1; if_wea[g] = wea; if_addr[g] = addr; if_data[g] = data;
    end else begin
      d_req[g] = 1'b1; d_wea[g] = wea; d_addr[g] = addr; d_data[g] = data;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (side == S_IF) ? if_gnt[g] : d_gnt[g];
    end
    if (!got) fail_evt("gnt_timeout", "no grant", $sformatf("grant on side %0d", side));
    if (!hold || !got) begin
      if (side == S_IF) if_req[g] = 1'b0;
      else              d_req[g]  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy[0] && !busy[1];
    end
    if (!done) fail_evt("idle_timeout", "still busy or events pending", "idle");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int g = 0; g < 2; g++) begin
      if_req[g] = 1'b0; if_wea[g] = 1'b0; if_addr[g] = '0; if_data[g] = '0;
      d_req[g]  = 1'b0; d_wea[g]  = 1'b0; d_addr[g]  = '0; d_data[g]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset state
    for (int g = 0; g < 2; g++) begin
      chk1("rst_busy", busy[g], 1'b0);
      chk1("rst_ena", sram_ena[g], 1'b0);
      chk1("rst_wea", sram_wea[g], 1'b0);
      chk1("rst_if_gnt", if_gnt[g], 1'b0);
      chk1("rst_d_gnt", d_gnt[g], 1'b0);
      chk1("rst_if_rvalid", if_rvalid[g], 1'b0);
      chk1("rst_d_rvalid", d_rvalid[g], 1'b0);
      chk("rst_addr", DW'(sram_addr[g]), '0);
      chk("rst_wdata", sram_wdata[g], '0);
      chk("rst_if_rdata", if_rdata[g], '0);
      chk("rst_d_rdata", d_rdata[g], '0);
    end

    // Single IF read of 0x005
    c = cyc;
    push(0, K_GNT_IF, c + 1, 1'b0, 10'h005, '0);
    push(0, K_RV_IF,  c + 3, 1'b0, 10'h005, {32{8'hA5}});
    side_txn(0, S_IF, 1'b0, 10'h005, '0, 1'b0);
    wait_idle();
    chk("t1_d_rdata_untouched", d_rdata[0], '0);

    // Simultaneous from reset: IF read 0x001 first, then D write 0x002
    do_reset();
    c = cyc;
    push(0, K_GNT_IF, c + 1, 1'b0, 10'h001, '0);
    push(0, K_RV_IF,  c + 3, 1'b0, 10'h001, {16{16'h0001}});
    push(0, K_GNT_D,  c + 5, 1'b1, 10'h002, 256'h1234);
    fork
      side_txn(0, S_IF, 1'b0, 10'h001, '0, 1'b0);
      side_txn(0, S_D,  1'b1, 10'h002, 256'h1234, 1'b0);
    join
    wait_idle();

    // Round robin with both sides holding req: IF, D, IF, D
    c = cyc;
    push(0, K_GNT_IF, c + 1,  1'b0, 10'h010, '0);
    push(0, K_RV_IF,  c + 3,  1'b0, 10'h010, {16{16'h0010}});
    push(0, K_GNT_D,  c + 5,  1'b0, 10'h020, '0);
    push(0, K_RV_D,   c + 7,  1'b0, 10'h020, {16{16'h0020}});
    push(0, K_GNT_IF, c + 9,  1'b0, 10'h011, '0);
    push(0, K_RV_IF,  c + 11, 1'b0, 10'h011, {16{16'h0011}});
    push(0, K_GNT_D,  c + 13, 1'b0, 10'h021, '0);
    push(0, K_RV_D,   c + 15, 1'b0, 10'h021, {16{16'h0021}});
    fork
      begin
        side_txn(0, S_IF, 1'b0, 10'h010, '0, 1'b1);
        side_txn(0, S_IF, 1'b0, 10'h011, '0, 1'b0);
      end
      begin
        side_txn(0, S_D, 1'b0, 10'h020, '0, 1'b1);
        side_txn(0, S_D, 1'b0, 10'h021, '0, 1'b0);
      end
    join
    wait_idle();
    chk("rr_if_rdata_final", if_rdata[0], {16{16'h0011}});
    chk("rr_d_rdata_final", d_rdata[0], {16{16'h0021}});

    // D write only: grant with ena/wea, no rvalid, idle next cycle
    c = cyc;
    push(0, K_GNT_D, c + 1, 1'b1, 10'h3FF, {8{32'hCAFEF00D}});
    side_txn(0, S_D, 1'b1, 10'h3FF, {8{32'hCAFEF00D}}, 1'b0);
    @(negedge clk);
    chk1("wr_idle_next_cycle", busy[0], 1'b0);
    repeat (3) @(negedge clk);

    // Async reset while an IF read sits in WAIT
    c = cyc;
    push(0, K_GNT_IF, c + 1, 1'b0, 10'h007, '0);
    side_txn(0, S_IF, 1'b0, 10'h007, '0, 1'b0);
    @(posedge clk);
    #1 chk1("wait_busy_before_rst", busy[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk1("arst_busy", busy[0], 1'b0);
    chk1("arst_ena", sram_ena[0], 1'b0);
    chk1("arst_if_rvalid", if_rvalid[0], 1'b0);
    chk1("arst_d_rvalid", d_rvalid[0], 1'b0);
    chk("arst_if_rdata", if_rdata[0], '0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    c = cyc;
    push(0, K_GNT_IF, c + 1, 1'b0, 10'h008, '0);
    push(0, K_RV_IF,  c + 3, 1'b0, 10'h008, {16{16'h0008}});
    side_txn(0, S_IF, 1'b0, 10'h008, '0, 1'b0);
    wait_idle();

    // READ_LATENCY=3 instance: D read 0x0AA, rvalid at t+5
    c = cyc;
    push(1, K_GNT_D, c + 1, 1'b0, 10'h0AA, '0);
    push(1, K_RV_D,  c + 5, 1'b0, 10'h0AA, {16{16'h00AA}});
    side_txn(1, S_D, 1'b0, 10'h0AA, '0, 1'b0);
    wait_idle();
    chk("rl3_if_rdata_untouched", if_rdata[1], '0);

    repeat (2) @(negedge clk);
    chk_int("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
